dz_countdown_ctrl: RTL and testbench

Sequencer for the dot-matrix countdown display. It generates the displayed digit (START_NUM down to 0) from a prescaled one-second tick. It also drives the row-scan strobe and the per-digit colour phase (red, then green, then yellow). It sits between the board buttons and the dot-matrix glyph/driver stage, which consumes `num`, `row_sel` and `color`.

---
 rtl/dz_pkg.sv | 33 +++
 rtl/dz_prescaler.sv | 36 +++
 rtl/dz_countdown_ctrl.sv | 140 ++++++++++++++
 tb/tb_dz_countdown_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dz_pkg.sv
// Shared types, colour codes and helpers for the dot-matrix countdown sequencer.
package dz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } dz_state_e;

    localparam logic [1:0] COL_OFF = 2'd0;
    localparam logic [1:0] COL_RED = 2'd1;
    localparam logic [1:0] COL_GRN = 2'd2;
    localparam logic [1:0] COL_YEL = 2'd3;

    function automatic logic [1:0] next_color(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            COL_RED: nxt = COL_GRN;
            COL_GRN: nxt = COL_YEL;
            COL_YEL: nxt = COL_RED;
            default: nxt = COL_RED;
        endcase
        return nxt;
    endfunction

    function automatic logic [7:0] row_onehot(input logic [2:0] sel);
        logic [7:0] onehot;
        onehot = 8'b0000_0001 << sel;
        return onehot;
    endfunction

endpackage

// File: rtl/dz_prescaler.sv
// Modulo-N counter with enable and synchronous clear; tick is high on the enabled terminal count.
module dz_prescaler #(
    parameter int unsigned N = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_r;

    assign tick = en && (cnt_r == LAST);

    // Count 0..N-1 while enabled, holding otherwise; clear wins over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/dz_countdown_ctrl.sv
// Countdown sequencer: run/pause/done FSM, digit and colour registers, and row-scan strobe.
module dz_countdown_ctrl
    import dz_pkg::*;
#(
    parameter int unsigned SEC_DIV   = 50_000_000,
    parameter int unsigned SCAN_DIV  = 5_000,
    parameter int unsigned START_NUM = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [2:0] num,
    output logic [1:0] color,
    output logic [2:0] row_sel,
    output logic [7:0] row,
    output logic       running,
    output logic       done
);

    localparam logic [2:0] START_VAL = 3'(START_NUM);

    dz_state_e state_r;
    logic      sec_tick_s;
    logic      sec_en_s;
    logic      sec_clr_s;
    logic      scan_tick_s;

    // The second counter only advances in RUN; it freezes in PAUSE and is zeroed elsewhere.
    assign sec_en_s  = (state_r == ST_RUN);
    assign sec_clr_s = start || clear || (state_r == ST_IDLE) || (state_r == ST_DONE);

    dz_prescaler #(.N(SEC_DIV)) u_sec_div (
        .clk  (clk),
        .rst  (rst),
        .en   (sec_en_s),
        .clr  (sec_clr_s),
        .tick (sec_tick_s)
    );

    dz_prescaler #(.N(SCAN_DIV)) u_scan_div (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .clr  (1'b0),
        .tick (scan_tick_s)
    );

    // Control FSM with registered digit, colour, running and done outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            num     <= START_VAL;
            color   <= COL_RED;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                state_r <= ST_IDLE;
                num     <= START_VAL;
                color   <= COL_RED;
                running <= 1'b0;
            end else if (start) begin
                state_r <= ST_RUN;
                num     <= START_VAL;
                color   <= COL_RED;
                running <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        num     <= START_VAL;
                        color   <= COL_RED;
                        running <= 1'b0;
                    end
                    ST_RUN: begin
                        // A tick coinciding with pause is still consumed so no step is lost.
                        if (sec_tick_s && (num == 3'd0)) begin
                            state_r <= ST_DONE;
                            color   <= COL_OFF;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            if (sec_tick_s) begin
                                num   <= num - 3'd1;
                                color <= next_color(color);
                            end else begin
                                num   <= num;
                                color <= color;
                            end
                            if (pause) begin
                                state_r <= ST_PAUSE;
                                running <= 1'b0;
                            end else begin
                                state_r <= ST_RUN;
                                running <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (pause) begin
                            state_r <= ST_RUN;
                            running <= 1'b1;
                        end else begin
                            state_r <= ST_PAUSE;
                            running <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        num     <= 3'd0;
                        color   <= COL_OFF;
                        running <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        num     <= START_VAL;
                        color   <= COL_RED;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Row scan runs in every state; row is kept as the registered decode of row_sel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_sel <= 3'd0;
            row     <= 8'b0000_0001;
        end else if (scan_tick_s) begin
            row_sel <= row_sel + 3'd1;
            row     <= row_onehot(row_sel + 3'd1);
        end else begin
            row_sel <= row_sel;
            row     <= row;
        end
    end

endmodule

// File: tb/tb_dz_countdown_ctrl.sv
// Directed self-checking bench for dz_countdown_ctrl with SEC_DIV=10, SCAN_DIV=2, START_NUM=5.
module tb_dz_countdown_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] num;
    logic [1:0] color;
    logic [2:0] row_sel;
    logic [7:0] row;
    logic       running;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    dz_countdown_ctrl #(
        .SEC_DIV   (10),
        .SCAN_DIV  (2),
        .START_NUM (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pause   (pause),
        .clear   (clear),
        .num     (num),
        .color   (color),
        .row_sel (row_sel),
        .row     (row),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge and counting done pulses.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
    endtask

    task automatic pulse(input logic s, input logic p, input logic c);
        start = s;
        pause = p;
        clear = c;
        step(1);
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
    endtask

    logic [2:0] exp_sel;
    logic [7:0] exp_row;
    logic [1:0] col_tab [5];
    int         d0;

    initial begin
        col_tab[0] = 2'd2; col_tab[1] = 2'd3; col_tab[2] = 2'd1;
        col_tab[3] = 2'd2; col_tab[4] = 2'd3;

        // Reset state and idle scan walk
        step(3);
        check_eq("rst_num", num, 5);
        check_eq("rst_color", color, 1);
        check_eq("rst_row", row, 8'h01);
        check_eq("rst_row_sel", row_sel, 0);
        check_eq("rst_running", running, 0);
        check_eq("rst_done", done, 0);
        rst = 1'b1;
        exp_sel = 3'd0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            exp_row = 8'h01 << exp_sel;
            check_eq("scan_hold", row, exp_row);
            step(1);
            exp_sel = exp_sel + 3'd1;
            exp_row = 8'h01 << exp_sel;
            check_eq("scan_step", row, exp_row);
            check_eq("scan_sel", row_sel, exp_sel);
        end
        check_eq("idle_num", num, 5);
        check_eq("idle_color", color, 1);
        check_eq("idle_running", running, 0);

        // Full run to completion
        d0 = done_cnt;
        pulse(1'b1, 1'b0, 1'b0);
        check_eq("start_running", running, 1);
        check_eq("start_num", num, 5);
        check_eq("start_color", color, 1);
        for (int k = 0; k < 5; k++) begin
            step(9);
            check_eq("run_before_dec", num, 5 - k);
            step(1);
            check_eq("run_dec_num", num, 4 - k);
            check_eq("run_dec_color", color, col_tab[k]);
        end
        step(9);
        check_eq("pre_done", done, 0);
        check_eq("pre_done_running", running, 1);
        step(1);
        check_eq("done_pulse", done, 1);
        check_eq("done_num", num, 0);
        check_eq("done_color", color, 0);
        check_eq("done_running", running, 0);
        step(1);
        check_eq("done_single", done, 0);
        check_eq("done_count", done_cnt - d0, 1);
        step(5);
        check_eq("done_hold_num", num, 0);

        // Clear to IDLE, pause ignored there
        pulse(1'b0, 1'b0, 1'b1);
        check_eq("clear_num", num, 5);
        check_eq("clear_color", color, 1);
        pulse(1'b0, 1'b1, 1'b0);
        check_eq("idle_pause_ignored", running, 0);
        step(15);
        check_eq("idle_hold_num", num, 5);

        // Pause 3 cycles after first decrement, hold 25 cycles, resume
        pulse(1'b1, 1'b0, 1'b0);
        step(10);
        check_eq("p_first_dec", num, 4);
        step(2);
        pulse(1'b0, 1'b1, 1'b0);
        check_eq("p_paused_running", running, 0);
        step(12);
        check_eq("p_mid_num", num, 4);
        step(12);
        check_eq("p_end_num", num, 4);
        pulse(1'b0, 1'b1, 1'b0);
        check_eq("p_resume_running", running, 1);
        step(6);
        check_eq("p_resume_hold", num, 4);
        step(1);
        check_eq("p_resume_dec", num, 3);
        check_eq("p_resume_color", color, 3);

        // Coincident start/pause/clear in RUN: clear wins
        pulse(1'b1, 1'b1, 1'b1);
        check_eq("coinc_running", running, 0);
        check_eq("coinc_num", num, 5);
        check_eq("coinc_color", color, 1);
        step(12);
        check_eq("coinc_idle_hold", num, 5);

        // Restart from DONE and mid-RUN
        pulse(1'b1, 1'b0, 1'b0);
        step(60);
        check_eq("r_done", done, 1);
        pulse(1'b1, 1'b0, 1'b0);
        check_eq("r_done_running", running, 1);
        check_eq("r_done_num", num, 5);
        check_eq("r_done_color", color, 1);
        step(30);
        check_eq("r_mid_num", num, 2);
        step(3);
        pulse(1'b1, 1'b0, 1'b0);
        check_eq("r_mid_restart_num", num, 5);
        check_eq("r_mid_restart_color", color, 1);
        check_eq("r_mid_restart_running", running, 1);

        // Asynchronous reset mid-run at num 3
        step(20);
        check_eq("rr_num3", num, 3);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rr_num", num, 5);
        check_eq("rr_color", color, 1);
        check_eq("rr_running", running, 0);
        check_eq("rr_done", done, 0);
        check_eq("rr_row", row, 8'h01);
        check_eq("rr_row_sel", row_sel, 0);
        d0 = done_cnt;
        step(3);
        rst = 1'b1;
        check_eq("rr_rel_row", row, 8'h01);
        step(1);
        check_eq("rr_rel_row_hold", row, 8'h01);
        step(1);
        check_eq("rr_rel_row_step", row, 8'h02);
        step(70);
        check_eq("rr_no_done", done_cnt - d0, 0);
        check_eq("rr_idle_num", num, 5);
        check_eq("rr_idle_running", running, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
